// File: rtl/brpred_pkg.sv
// Purpose : shared types and 2-bit saturating counter helpers for the branch predictor.
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
package brpred_pkg;

  typedef logic [1:0] sat_ctr_t;

  localparam sat_ctr_t STRONG_NT = 2'b00;
  localparam sat_ctr_t WEAK_NT   = 2'b01;
  localparam sat_ctr_t WEAK_T    = 2'b10;
  localparam sat_ctr_t STRONG_T  = 2'b11;

  // Step one position toward the resolved direction, clamping at both ends.
  function automatic sat_ctr_t sat_ctr_next(input sat_ctr_t state, input logic taken);
    sat_ctr_t nxt;
    nxt = state;
    if (taken) begin
      if (state != STRONG_T) nxt = state + 2'b01;
    end else begin
      if (state != STRONG_NT) nxt = state - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/brpred_btb_bht_predictor_if.sv
// Purpose : fetch-side lookup and execute-side update bundle of the branch predictor.
// Latency : n/a (wires only).
// Backpressure: none; every update with upd_val high is consumed.
// Ports: master = fetch/execute pipeline, slave = predictor.
interface brpred_btb_bht_predictor_if #(
  parameter int p_pc_nbits  = 32,
  parameter int p_ghr_nbits = 6
);
  logic                   pred_val;
  logic [p_pc_nbits-1:0]  pred_pc;
  logic                   pred_hit;
  logic                   pred_taken;
  logic [p_pc_nbits-1:0]  pred_targ;
  logic [p_ghr_nbits-1:0] pred_ghr;

  logic                   upd_val;
  logic [p_pc_nbits-1:0]  upd_pc;
  logic                   upd_taken;
  logic [p_pc_nbits-1:0]  upd_targ;
  logic [p_ghr_nbits-1:0] upd_ghr;

  modport master (
    output pred_val, pred_pc, upd_val, upd_pc, upd_taken, upd_targ, upd_ghr,
    input  pred_hit, pred_taken, pred_targ, pred_ghr
  );

  modport slave (
    input  pred_val, pred_pc, upd_val, upd_pc, upd_taken, upd_targ, upd_ghr,
    output pred_hit, pred_taken, pred_targ, pred_ghr
  );
endinterface

// File: rtl/brpred_sat_counter_table.sv
// Purpose : table of 2-bit saturating direction counters (BHT).
// Latency : combinational read; write lands on the next clk edge (read sees old value same cycle).
// Backpressure: none; a write is taken every cycle wr_en is high.
// Ports: clk/reset (sync, active-high), rd_idx/rd_ctr read port, wr_en/wr_idx/wr_taken train port.
module brpred_sat_counter_table
  import brpred_pkg::*;
#(
  parameter int p_entries   = 64,
  parameter int p_idx_nbits = $clog2(p_entries)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_idx_nbits-1:0] rd_idx,
  output sat_ctr_t               rd_ctr,
  input  logic                   wr_en,
  input  logic [p_idx_nbits-1:0] wr_idx,
  input  logic                   wr_taken
);

  sat_ctr_t ctr [p_entries];

  assign rd_ctr = ctr[rd_idx];

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < p_entries; i++) ctr[i] <= WEAK_NT;
    end else if (wr_en) begin
      ctr[wr_idx] <= sat_ctr_next(ctr[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/brpred_btb_bht_predictor.sv
// Purpose : direct-mapped BTB plus 2-bit counter BHT; optional gshare history (BRPRED_GSHARE_EN).
// Latency : lookup combinational (zero cycles); updates visible the cycle after upd_val.
// Backpressure: none; one resolved-branch update accepted every cycle upd_val is high.
// Ports: clk, reset (sync, active-high), bp (slave modport: pred_* lookup, upd_* training).
// Config macro: BRPRED_GSHARE_EN -- XOR global history into the BHT index; otherwise pred_ghr is 0.
module brpred_btb_bht_predictor
  import brpred_pkg::*;
#(
  parameter int p_pc_nbits    = 32,
  parameter int p_btb_entries = 16,
  parameter int p_bht_entries = 64,
  parameter int p_ghr_nbits   = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  brpred_btb_bht_predictor_if.slave bp
);

  localparam int BTB_IW = $clog2(p_btb_entries);
  localparam int BHT_IW = $clog2(p_bht_entries);
  localparam int TAG_W  = p_pc_nbits - BTB_IW - 2;

  // BTB storage: only valid bits need reset, tag/target are qualified by valid.
  logic                  btb_vld  [p_btb_entries];
  logic [TAG_W-1:0]      btb_tag  [p_btb_entries];
  logic [p_pc_nbits-1:0] btb_targ [p_btb_entries];

  logic [BTB_IW-1:0]     pred_btb_idx, upd_btb_idx;
  logic [TAG_W-1:0]      pred_tag, upd_tag;
  logic [BHT_IW-1:0]     pred_hist, upd_hist;
  logic [BHT_IW-1:0]     pred_bht_idx, upd_bht_idx;
  sat_ctr_t              pred_ctr;
  logic                  hit, taken;
  logic [p_pc_nbits-1:0] seq_pc;

  assign pred_btb_idx = bp.pred_pc[BTB_IW+1:2];
  assign pred_tag     = bp.pred_pc[p_pc_nbits-1:BTB_IW+2];
  assign upd_btb_idx  = bp.upd_pc[BTB_IW+1:2];
  assign upd_tag      = bp.upd_pc[p_pc_nbits-1:BTB_IW+2];

`ifdef BRPRED_GSHARE_EN
  logic [p_ghr_nbits-1:0] ghr;
  logic [p_ghr_nbits:0]   ghr_shift;

  // Widened concat keeps the shift legal for a 1-bit history.
  assign ghr_shift = {ghr, bp.upd_taken};

  always_ff @(posedge clk) begin
    if (reset) ghr <= '0;
    else if (bp.upd_val) ghr <= ghr_shift[p_ghr_nbits-1:0];
  end

  // Training uses the history that was live when the branch was predicted.
  assign pred_hist   = BHT_IW'(ghr);
  assign upd_hist    = BHT_IW'(bp.upd_ghr);
  assign bp.pred_ghr = reset ? '0 : ghr;
`else
  logic unused_upd_ghr;
  assign unused_upd_ghr = ^bp.upd_ghr;
  assign pred_hist      = '0;
  assign upd_hist       = '0;
  assign bp.pred_ghr    = '0;
`endif

  logic unused_upd_pc_lo;
  assign unused_upd_pc_lo = ^bp.upd_pc[1:0];

  assign pred_bht_idx = bp.pred_pc[BHT_IW+1:2] ^ pred_hist;
  assign upd_bht_idx  = bp.upd_pc[BHT_IW+1:2] ^ upd_hist;

  brpred_sat_counter_table #(
    .p_entries   (p_bht_entries),
    .p_idx_nbits (BHT_IW)
  ) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pred_bht_idx),
    .rd_ctr   (pred_ctr),
    .wr_en    (bp.upd_val),
    .wr_idx   (upd_bht_idx),
    .wr_taken (bp.upd_taken)
  );

  // Not-taken resolutions leave the BTB alone; taken ones allocate or retarget.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < p_btb_entries; i++) btb_vld[i] <= 1'b0;
    end else if (bp.upd_val && bp.upd_taken) begin
      btb_vld[upd_btb_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && bp.upd_val && bp.upd_taken) begin
      btb_tag[upd_btb_idx]  <= upd_tag;
      btb_targ[upd_btb_idx] <= bp.upd_targ;
    end
  end

  // Lookup reads pre-update state; there is deliberately no write bypass.
  assign seq_pc = bp.pred_pc + p_pc_nbits'(4);
  assign hit    = !reset && bp.pred_val && btb_vld[pred_btb_idx]
                  && (btb_tag[pred_btb_idx] == pred_tag);
  assign taken  = hit && pred_ctr[1];

  assign bp.pred_hit   = hit;
  assign bp.pred_taken = taken;
  assign bp.pred_targ  = taken ? btb_targ[pred_btb_idx] : seq_pc;

endmodule

// File: tb/tb_brpred_btb_bht_predictor.sv
// Purpose : directed self-checking bench for brpred_btb_bht_predictor (default params).
// Latency : lookups checked combinationally, updates checked the cycle after they are applied.
// Backpressure: n/a (predictor never stalls).
module tb_brpred_btb_bht_predictor;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  brpred_btb_bht_predictor_if #(.p_pc_nbits(32), .p_ghr_nbits(6)) bp_if ();

  brpred_btb_bht_predictor #(
    .p_pc_nbits    (32),
    .p_btb_entries (16),
    .p_bht_entries (64),
    .p_ghr_nbits   (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a lookup and compare the three prediction outputs.
  task automatic look(input string tag, input logic val, input logic [31:0] pc,
                      input logic hit, input logic taken, input logic [31:0] targ);
    bp_if.pred_val = val;
    bp_if.pred_pc  = pc;
    #1;
    check({tag, ".hit"},   {31'b0, bp_if.pred_hit},   {31'b0, hit});
    check({tag, ".taken"}, {31'b0, bp_if.pred_taken}, {31'b0, taken});
    check({tag, ".targ"},  bp_if.pred_targ, targ);
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] targ,
                         input logic [5:0] ghr);
    bp_if.upd_val   = 1'b1;
    bp_if.upd_pc    = pc;
    bp_if.upd_taken = tk;
    bp_if.upd_targ  = targ;
    bp_if.upd_ghr   = ghr;
  endtask

  // One update applied across exactly one rising edge.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] targ,
                     input logic [5:0] ghr);
    @(negedge clk);
    set_upd(pc, tk, targ, ghr);
    @(posedge clk);
    #1;
    bp_if.upd_val = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bp_if.pred_val  = 1'b0;
    bp_if.pred_pc   = '0;
    bp_if.upd_val   = 1'b0;
    bp_if.upd_pc    = '0;
    bp_if.upd_taken = 1'b0;
    bp_if.upd_targ  = '0;
    bp_if.upd_ghr   = '0;

    repeat (2) @(posedge clk);
    #1;
    look("in_reset", 1'b1, 32'h100, 1'b0, 1'b0, 32'h104);
    check("in_reset.ghr", {26'b0, bp_if.pred_ghr}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    look("post_reset", 1'b1, 32'h100, 1'b0, 1'b0, 32'h104);
    check("post_reset.ghr", {26'b0, bp_if.pred_ghr}, 32'h0);

`ifdef BRPRED_GSHARE_EN
    // History T,T,NT on an unrelated branch: GHR 000001 -> 000011 -> 000110.
    upd(32'h800, 1'b1, 32'h900, 6'h00);
    upd(32'h800, 1'b1, 32'h900, 6'h00);
    upd(32'h800, 1'b0, 32'h900, 6'h00);
    #1;
    check("gshare.ghr_ttn", {26'b0, bp_if.pred_ghr}, 32'h06);
    // Train 0x100 with upd_ghr=0x0D while live GHR is 0x06; GHR becomes 0x0D.
    // Only ctr[0^0x0D] reaching WEAK_T makes the next lookup predict taken.
    upd(32'h100, 1'b1, 32'h200, 6'h0D);
    look("gshare.xor_idx", 1'b1, 32'h100, 1'b1, 1'b1, 32'h200);
    check("gshare.ghr_after", {26'b0, bp_if.pred_ghr}, 32'h0D);
`else
    // Allocate and predict taken (ctr 01 -> 10).
    upd(32'h100, 1'b1, 32'h200, 6'h3F);
    look("alloc", 1'b1, 32'h100, 1'b1, 1'b1, 32'h200);
    check("alloc.ghr", {26'b0, bp_if.pred_ghr}, 32'h0);

    // Not-taken walk down to 00 and saturate there.
    upd(32'h100, 1'b0, 32'h0, 6'h0);
    look("nt1", 1'b1, 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h0, 6'h0);
    look("nt2", 1'b1, 32'h100, 1'b1, 1'b0, 32'h104);
    repeat (5) upd(32'h100, 1'b0, 32'h0, 6'h0);
    look("nt_sat", 1'b1, 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h200, 6'h0);
    look("from00_t1", 1'b1, 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h200, 6'h0);
    look("from00_t2", 1'b1, 32'h100, 1'b1, 1'b1, 32'h200);

    // Saturate at 11, then two not-takens: 10 (taken) then 01 (not taken).
    repeat (3) upd(32'h100, 1'b1, 32'h200, 6'h0);
    upd(32'h100, 1'b0, 32'h0, 6'h0);
    look("t_sat_nt1", 1'b1, 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0, 6'h0);
    look("t_sat_nt2", 1'b1, 32'h100, 1'b1, 1'b0, 32'h104);

    // Conflict on btb_idx 0: 0x500 replaces 0x100 (shared ctr ends at 11).
    upd(32'h100, 1'b1, 32'h200, 6'h0);
    upd(32'h500, 1'b1, 32'h600, 6'h0);
    look("evicted", 1'b1, 32'h100, 1'b0, 1'b0, 32'h104);
    look("replacer", 1'b1, 32'h500, 1'b1, 1'b1, 32'h600);
    look("val_low", 1'b0, 32'h500, 1'b0, 1'b0, 32'h504);
    look("pc_wrap", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // Not-taken never allocates; taken allocates but weak counter predicts NT.
    upd(32'h104, 1'b0, 32'h300, 6'h0);
    look("nt_noalloc", 1'b1, 32'h104, 1'b0, 1'b0, 32'h108);
    upd(32'h104, 1'b1, 32'h300, 6'h0);
    look("hit_not_taken", 1'b1, 32'h104, 1'b1, 1'b0, 32'h108);

    // Same-cycle update and lookup: lookup sees pre-update contents.
    @(negedge clk);
    set_upd(32'h108, 1'b1, 32'h400, 6'h0);
    look("same_cyc_old", 1'b1, 32'h108, 1'b0, 1'b0, 32'h10C);
    @(posedge clk);
    #1;
    bp_if.upd_val = 1'b0;
    look("same_cyc_new", 1'b1, 32'h108, 1'b1, 1'b1, 32'h400);
    @(negedge clk);
    set_upd(32'h108, 1'b1, 32'h440, 6'h0);
    look("retarget_old", 1'b1, 32'h108, 1'b1, 1'b1, 32'h400);
    @(posedge clk);
    #1;
    bp_if.upd_val = 1'b0;
    look("retarget_new", 1'b1, 32'h108, 1'b1, 1'b1, 32'h440);

    // Reset with a coincident update: outputs forced, everything cleared, no write.
    @(negedge clk);
    reset = 1'b1;
    set_upd(32'h10C, 1'b1, 32'h700, 6'h0);
    look("rst_forced", 1'b1, 32'h108, 1'b0, 1'b0, 32'h10C);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bp_if.upd_val = 1'b0;
    look("rst_clr_108", 1'b1, 32'h108, 1'b0, 1'b0, 32'h10C);
    look("rst_nowrite", 1'b1, 32'h10C, 1'b0, 1'b0, 32'h110);
    look("rst_clr_500", 1'b1, 32'h500, 1'b0, 1'b0, 32'h504);
    // Counter 0 was 11 before reset; from 01, T then NT lands at 01 (not taken).
    upd(32'h100, 1'b1, 32'h200, 6'h0);
    upd(32'h100, 1'b0, 32'h0, 6'h0);
    look("rst_ctr_weak", 1'b1, 32'h100, 1'b1, 1'b0, 32'h104);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
